// File: rtl/div_arbiter.sv
// Round-robin share of one iterative divider between two pipes; operands latched at grant, start 1 cycle after request, result 1 cycle after div_ready_i.
// No backpressure on the result: the waiting pipe is held via stallreq_o, and a flushed owner annuls the divider and drains for CANCEL_CYCLES.
module div_arbiter #(
    parameter int CANCEL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic [1:0]  signed_i,
    input  logic [31:0] op1_p0_i,
    input  logic [31:0] op2_p0_i,
    input  logic [31:0] op1_p1_i,
    input  logic [31:0] op2_p1_i,
    input  logic [1:0]  flush_i,
    output logic [1:0]  stallreq_o,
    output logic [1:0]  result_valid_o,
    output logic [63:0] result_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam int CW = $clog2(CANCEL_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RELEASE,
        ST_CANCEL
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_owner;
    logic          r_last_grant;
    logic          r_signed;
    logic [31:0]   r_op1;
    logic [31:0]   r_op2;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_result;
    logic [1:0]    r_result_vld;

    logic [1:0]    w_elig;
    logic          w_grant_vld;
    logic          w_grant_pipe;
    logic          w_owner_flush;
    logic          w_done;
    logic          w_cancel_done;

    assign w_elig        = req_i & ~flush_i;
    assign w_grant_vld   = (r_state == ST_IDLE) && (w_elig != 2'b00);
    // Contention goes to the pipe that did not win last time.
    assign w_grant_pipe  = (w_elig == 2'b11) ? ~r_last_grant : w_elig[1];
    assign w_owner_flush = flush_i[r_owner];
    assign w_done        = (r_state == ST_BUSY) && !w_owner_flush && div_ready_i;
    assign w_cancel_done = (r_cnt == CW'(CANCEL_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_owner_flush) begin
                    w_next_state = ST_CANCEL;
                end else if (div_ready_i) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_next_state = ST_IDLE;
            end
            ST_CANCEL: begin
                if (w_cancel_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        case (r_state)
            ST_BUSY:   div_start_o = 1'b1;
            ST_CANCEL: div_annul_o = (r_cnt == '0);
            default: begin
                div_start_o = 1'b0;
                div_annul_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_signed     <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_result_vld <= 2'b00;
        end else begin
            if (w_grant_vld) begin
                r_owner      <= w_grant_pipe;
                r_last_grant <= w_grant_pipe;
                r_signed     <= signed_i[w_grant_pipe];
                r_op1        <= w_grant_pipe ? op1_p1_i : op1_p0_i;
                r_op2        <= w_grant_pipe ? op2_p1_i : op2_p0_i;
            end
            r_cnt <= ((r_state == ST_CANCEL) && !w_cancel_done) ? r_cnt + CW'(1) : '0;
            if (w_done) begin
                r_result <= div_result_i;
            end
            r_result_vld <= w_done ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign div_signed_o   = r_signed;
    assign div_opdata1_o  = r_op1;
    assign div_opdata2_o  = r_op2;
    assign result_o       = r_result;
    assign result_valid_o = r_result_vld;
    assign stallreq_o     = req_i & ~flush_i & ~r_result_vld;

endmodule
